mem_arb: RTL and testbench

Parametrised multi-port memory controller for the RV32I core. It arbitrates NPORT requestors (instruction fetch, load/store, and optional future ports such as an I-cache refill or DMA) onto the single byte-serial RAM/IO bus. It serialises byte, half and word accesses into per-byte bus cycles and returns assembled read data with a one-cycle done pulse. It replaces the fixed two-client memory controller and adds per-port flush and selectable arbitration.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_arb.sv | 145 ++++++++++++++
 tb/tb_mem_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
package mem_arb_pkg;

  localparam logic [1:0] SizeB = 2'd0;
  localparam logic [1:0] SizeH = 2'd1;
  localparam logic [1:0] SizeW = 2'd2;

  // Reads here pop the UART receive FIFO, so they must never be repeated.
  localparam logic [31:0] IoBase = 32'h0003_0000;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbRd   = 2'd1,
    ArbWr   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [2:0]      nbytes;
    logic [3:0][7:0] wdata;
  } acc_t;

  // Size code 3 is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SizeB:   return 3'd1;
      SizeH:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// One-hot grant picker. MEM_ARB_RR_EN selects round-robin starting at ptr;
// otherwise fixed priority with the lowest index winning.
module mem_arb_pick #(
  parameter int NPORT = 2
`ifdef MEM_ARB_RR_EN
  ,
  parameter int PW    = 1
`endif
) (
  input  logic [NPORT-1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic [PW-1:0]    ptr,
`endif
  output logic [NPORT-1:0] grant
);

`ifdef MEM_ARB_RR_EN
  logic [NPORT-1:0]   rot, rot_g;
  logic [2*NPORT-1:0] gnt2;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot   = NPORT'({req, req} >> ptr);
    rot_g = rot & (~rot + NPORT'(1));
    gnt2  = {{NPORT{1'b0}}, rot_g} << ptr;
    grant = gnt2[NPORT-1:0] | gnt2[2*NPORT-1:NPORT];
  end
`else
  assign grant = req & (~req + NPORT'(1));
`endif

endmodule

// File: rtl/mem_arb.sv
// Multi-port arbiter onto a byte-serial RAM/IO bus; serialises each access
// into per-byte cycles. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int NPORT  = 2,
  parameter int ADDR_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NPORT-1:0]              port_req,
  input  logic [NPORT-1:0]              port_we,
  input  logic [NPORT-1:0][1:0]         port_size,
  input  logic [NPORT-1:0][ADDR_W-1:0]  port_addr,
  input  logic [NPORT-1:0][31:0]        port_wdata,
  input  logic [NPORT-1:0]              port_flush,
  output logic [NPORT-1:0]              port_done,
  output logic [NPORT-1:0][31:0]        port_rdata,
  input  logic [7:0]                    mem_din,
  output logic [7:0]                    mem_dout,
  output logic [31:0]                   mem_a,
  output logic                          mem_wr
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  arb_state_e        state;
  acc_t              acc;
  logic [ADDR_W-1:0] addr_q;
  logic [PW-1:0]     gq, gidx;
  logic [2:0]        cnt;   // bytes whose address has been put on the bus
  logic [2:0]        cap;   // cycles spent in RD; byte cap-1 is on mem_din
  logic [3:0][7:0]   rbuf, rd_next;
  logic [NPORT-1:0]  grant;

`ifdef MEM_ARB_RR_EN
  localparam logic [PW-1:0] LastPort = PW'(NPORT - 1);
  logic [PW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (state == ArbIdle && |port_req)
      ptr <= (gidx == LastPort) ? '0 : gidx + PW'(1);
  end

  mem_arb_pick #(.NPORT(NPORT), .PW(PW)) u_pick (
    .req   (port_req),
    .ptr   (ptr),
    .grant (grant)
  );
`else
  mem_arb_pick #(.NPORT(NPORT)) u_pick (
    .req   (port_req),
    .grant (grant)
  );
`endif

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NPORT; i++)
      if (grant[i]) gidx = PW'(i);
  end

  // The RAM answers one cycle after the address, so mem_din holds byte cap-1.
  always_comb begin
    rd_next = rbuf;
    if (cap != 3'd0) rd_next[2'(cap - 3'd1)] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ArbIdle;
      acc        <= '0;
      addr_q     <= '0;
      gq         <= '0;
      cnt        <= '0;
      cap        <= '0;
      rbuf       <= '0;
      port_done  <= '0;
      port_rdata <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
    end else begin
      port_done <= '0;
      case (state)
        ArbIdle: begin
          if (|port_req) begin
            gq         <= gidx;
            addr_q     <= port_addr[gidx];
            acc.nbytes <= size_bytes(port_size[gidx]);
            acc.wdata  <= port_wdata[gidx];
            cnt        <= 3'd1;
            cap        <= 3'd0;
            rbuf       <= '0;
            mem_a      <= 32'(port_addr[gidx]);
            if (port_we[gidx]) begin
              state    <= ArbWr;
              mem_wr   <= 1'b1;
              mem_dout <= port_wdata[gidx][7:0];
            end else begin
              state    <= ArbRd;
            end
          end
        end
        ArbRd: begin
          if (port_flush[gq]) begin
            state <= ArbIdle;
            mem_a <= '0;
          end else begin
            if (cnt < acc.nbytes) begin
              mem_a <= 32'(addr_q + ADDR_W'(cnt));
              cnt   <= cnt + 3'd1;
            end else begin
              mem_a <= '0;
            end
            rbuf <= rd_next;
            cap  <= cap + 3'd1;
            if (cap == acc.nbytes) begin
              state          <= ArbIdle;
              port_done[gq]  <= 1'b1;
              port_rdata[gq] <= rd_next;
            end
          end
        end
        ArbWr: begin
          if (cnt < acc.nbytes) begin
            mem_a    <= 32'(addr_q + ADDR_W'(cnt));
            mem_dout <= acc.wdata[2'(cnt)];
            cnt      <= cnt + 3'd1;
          end else begin
            state         <= ArbIdle;
            mem_a         <= '0;
            mem_dout      <= '0;
            mem_wr        <= 1'b0;
            port_done[gq] <= 1'b1;
          end
        end
        default: state <= ArbIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a registered byte RAM and a UART byte at IoBase.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int NPORT  = 2;
  localparam int ADDR_W = 32;
  localparam logic [7:0] UartByte = 8'hA5;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NPORT-1:0]             port_req, port_we, port_flush, port_done;
  logic [NPORT-1:0][1:0]        port_size;
  logic [NPORT-1:0][ADDR_W-1:0] port_addr;
  logic [NPORT-1:0][31:0]       port_wdata, port_rdata;
  logic [7:0]                   mem_din, mem_dout;
  logic [31:0]                  mem_a;
  logic                         mem_wr;

  mem_arb #(.NPORT(NPORT), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .port_req   (port_req),
    .port_we    (port_we),
    .port_size  (port_size),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .port_flush (port_flush),
    .port_done  (port_done),
    .port_rdata (port_rdata),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_a      (mem_a),
    .mem_wr     (mem_wr)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h100] <= 8'h11;
      ram[10'h101] <= 8'h22;
      ram[10'h102] <= 8'h33;
      ram[10'h103] <= 8'h44;
      ram[10'h010] <= 8'h5A;
      ram[10'h020] <= 8'h6B;
      mem_din      <= 8'h00;
    end else begin
      if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
      mem_din <= (mem_a == IoBase) ? UartByte : ram[mem_a[9:0]];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit drop_on_done;

  logic [31:0]      tr_a    [0:31];
  logic             tr_wr   [0:31];
  logic [7:0]       tr_dout [0:31];
  logic [NPORT-1:0] tr_done [0:31];
  logic [31:0]      tr_rd0  [0:31];
  logic [31:0]      tr_rd1  [0:31];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance into the next cycle and record the bus; a requestor drops req on done.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 32) begin
      tr_a[cyc]    = mem_a;
      tr_wr[cyc]   = mem_wr;
      tr_dout[cyc] = mem_dout;
      tr_done[cyc] = port_done;
      tr_rd0[cyc]  = port_rdata[0];
      tr_rd1[cyc]  = port_rdata[1];
    end
    for (int p = 0; p < NPORT; p++)
      if (drop_on_done && port_done[p]) port_req[p] = 1'b0;
  endtask

  task automatic start(input int p, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    port_we[p]    = we;
    port_size[p]  = sz;
    port_addr[p]  = a;
    port_wdata[p] = wd;
    port_req[p]   = 1'b1;
    cyc = 0;
    for (int i = 0; i < 32; i++) tr_done[i] = '0;
  endtask

  int n;
  logic [NPORT-1:0] any_done;

  initial begin
    rst = 1'b1;
    port_req = '0; port_we = '0; port_size = '0; port_addr = '0;
    port_wdata = '0; port_flush = '0; drop_on_done = 1'b1;
    repeat (3) step();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_done", 32'(port_done), 32'h0);
    chk("rst_rdata0", port_rdata[0], 32'h0);
    chk("rst_rdata1", port_rdata[1], 32'h0);
    rst = 1'b0;
    step(); step();

    // Word read on port 1.
    start(1, 1'b0, SizeW, 32'h100, 32'h0);
    repeat (8) step();
    for (int i = 0; i < 4; i++) chk("wrd_addr", tr_a[i+1], 32'h100 + 32'(i));
    chk("wrd_wr", 32'(tr_wr[1]), 32'h0);
    chk("wrd_a_after", tr_a[5], 32'h0);
    chk("wrd_no_early_done", 32'(tr_done[5]), 32'h0);
    chk("wrd_done", 32'(tr_done[6]), 32'h2);
    chk("wrd_rdata", tr_rd1[6], 32'h4433_2211);

    // Half write across a 512-byte boundary.
    start(1, 1'b1, SizeH, 32'h1FF, 32'h0000_BEEF);
    repeat (4) step();
    chk("hw_a1", tr_a[1], 32'h1FF);
    chk("hw_d1", 32'(tr_dout[1]), 32'hEF);
    chk("hw_wr1", 32'(tr_wr[1]), 32'h1);
    chk("hw_a2", tr_a[2], 32'h200);
    chk("hw_d2", 32'(tr_dout[2]), 32'hBE);
    chk("hw_no_early_done", 32'(tr_done[2]), 32'h0);
    chk("hw_done", 32'(tr_done[3]), 32'h2);
    chk("hw_wr3", 32'(tr_wr[3]), 32'h0);
    chk("hw_ram1ff", 32'(ram[10'h1FF]), 32'hEF);
    chk("hw_ram200", 32'(ram[10'h200]), 32'hBE);

    // Both ports hold byte reads continuously from reset.
    rst = 1'b1; step(); step(); rst = 1'b0;
    drop_on_done = 1'b0;
    start(0, 1'b0, SizeB, 32'h10, 32'h0);
    start(1, 1'b0, SizeB, 32'h20, 32'h0);
    repeat (12) step();
    port_req = '0;
    drop_on_done = 1'b1;
    chk("arb_done3", 32'(tr_done[3]), 32'h1);
    chk("arb_rdata3", tr_rd0[3], 32'h5A);
    chk("arb_gap4", 32'(tr_done[4]), 32'h0);
`ifdef MEM_ARB_RR_EN
    chk("arb_done6", 32'(tr_done[6]), 32'h2);
    chk("arb_rdata6", tr_rd1[6], 32'h6B);
    chk("arb_done9", 32'(tr_done[9]), 32'h1);
    chk("arb_done12", 32'(tr_done[12]), 32'h2);
`else
    chk("arb_done6", 32'(tr_done[6]), 32'h1);
    chk("arb_done9", 32'(tr_done[9]), 32'h1);
    chk("arb_done12", 32'(tr_done[12]), 32'h1);
`endif
    repeat (3) step();

    // Flush a port-0 word read in cycle 2.
    start(0, 1'b0, SizeW, 32'h100, 32'h0);
    step(); step();
    port_flush[0] = 1'b1;
    step();
    port_flush[0] = 1'b0;
    port_req[0]   = 1'b0;
    repeat (5) step();
    chk("fl_a1", tr_a[1], 32'h100);
    chk("fl_a2", tr_a[2], 32'h101);
    chk("fl_a3_idle", tr_a[3], 32'h0);
    any_done = '0; n = 0;
    for (int c = 1; c <= 8; c++) begin
      any_done |= tr_done[c];
      if (tr_a[c] == 32'h102 || tr_a[c] == 32'h103) n++;
    end
    chk("fl_no_done", 32'(any_done), 32'h0);
    chk("fl_no_late_addr", 32'(n), 32'h0);

    // UART byte read waiting behind a port-1 word write.
    start(1, 1'b1, SizeW, 32'h40, 32'h0102_0304);
    step();
    port_we[0] = 1'b0; port_size[0] = SizeB; port_addr[0] = IoBase; port_req[0] = 1'b1;
    repeat (11) step();
    chk("io_wdone", 32'(tr_done[5]), 32'h2);
    chk("io_addr", tr_a[6], IoBase);
    chk("io_rdone", 32'(tr_done[8]), 32'h1);
    chk("io_rdata", tr_rd0[8], 32'(UartByte));
    n = 0;
    for (int c = 1; c <= 12; c++)
      if (tr_a[c] == IoBase && !tr_wr[c]) n++;
    chk("io_single_read", 32'(n), 32'h1);
    chk("io_ram43", 32'(ram[10'h043]), 32'h01);

    // Reset during cycle 2 of a word write; the held request restarts after.
    start(0, 1'b1, SizeW, 32'h80, 32'hCAFE_F00D);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_wr", 32'(mem_wr), 32'h0);
    chk("rs_a", mem_a, 32'h0);
    chk("rs_dout", 32'(mem_dout), 32'h0);
    repeat (6) step();
    any_done = '0;
    for (int c = 1; c <= 7; c++) any_done |= tr_done[c];
    chk("rs_no_done", 32'(any_done), 32'h0);
    chk("rs_restart_a", tr_a[4], 32'h80);
    chk("rs_restart_wr", 32'(tr_wr[4]), 32'h1);
    chk("rs_done", 32'(tr_done[8]), 32'h1);
    chk("rs_ram83", 32'(ram[10'h083]), 32'hCA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
